mult_accum: RTL and testbench
=============================

MULT_ACCUM -- requirements
Module: mult_accum

Interface
REQ-001 Parameter ACC_W, default 12: accumulator/result width in bits; legal range 9..32.
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 p_valid  input  1  product from the 4-bit Booth multiplier stage is valid.
REQ-005 p_data  input  8  signed two's-complement product term.
REQ-006 p_last  input  1  marks p_data as the final term of the current vector; qualified by p_valid.
REQ-007 p_ready  output  1  block can accept a term this cycle.
REQ-008 acc_valid  output  1  completed dot-product result available.
REQ-009 acc_ready  input  1  consumer accepts the result.
REQ-010 acc_data  output  ACC_W  signed accumulated sum of the vector.
REQ-011 acc_cnt  output  8  number of terms in the vector; saturates at 255.
REQ-012 acc_ovf  output  1  sticky per-vector flag: some addition overflowed ACC_W signed range.

Function
REQ-013 Term accepted on a cycle where p_valid && p_ready; no other input value has effect.
REQ-014 The FSM SHALL have exactly three states: IDLE (no partial sum), ACCUM (partial sum held), HOLD (result presented).
REQ-015 IDLE: accepted term with p_last=0 -> sum=sext(p_data), cnt=1 -> ACCUM; with p_last=1 -> HOLD holding that single term.
REQ-016 ACCUM: accepted term -> sum+=sext(p_data), cnt+=1 (saturating); p_last=1 -> HOLD; no accept -> stay, sum unchanged.
REQ-017 HOLD: acc_valid=1; acc_data, acc_cnt, acc_ovf stable until acc_ready=1.
REQ-018 p_ready = (state != HOLD) || acc_ready (combinational).
REQ-019 HOLD with acc_ready=1 and a term accepted the same cycle: result retires, and the term starts a new vector from zero per REQ-015 (back-to-back, no bubble).
REQ-020 HOLD with acc_ready=1 and no accepted term -> IDLE.
REQ-021 Latency: term with p_last accepted in cycle N -> acc_valid=1 in cycle N+1.
REQ-022 Sum arithmetic: p_data sign-extended to ACC_W+1 bits; overflow = result outside ACC_W signed range; overflow sets acc_ovf for the vector.
REQ-023 acc_ovf clears at the start of each new vector.
REQ-024 acc_data/acc_cnt/acc_ovf in IDLE/ACCUM SHALL show the running partial values; only meaningful while acc_valid=1.

Reset
REQ-025 rst=1 at a rising edge -> state IDLE, acc_valid=0, acc_data=0, acc_cnt=0, acc_ovf=0, next cycle p_ready=1.
REQ-026 rst takes priority over every handshake; a partial sum or held result is discarded mid-operation without being presented.
REQ-027 While rst=1, no term is accepted, regardless of p_ready.

Configuration
REQ-028 Macro MULT_ACCUM_SAT_EN defined: on overflow acc_data clamps to +2^(ACC_W-1)-1 or -2^(ACC_W-1) and stays clamped until further terms bring it back in range from the clamped value.
REQ-029 MULT_ACCUM_SAT_EN undefined: acc_data wraps modulo 2^ACC_W; acc_ovf is still produced identically.

Verification
REQ-030 Reset, then terms 3,-5,7(last) with acc_ready=1 -> acc_valid one cycle after 7, acc_data=5, acc_cnt=3, acc_ovf=0.
REQ-031 Single term -56 with p_last, acc_ready=0 for 4 cycles -> acc_data=-56, acc_cnt=1 held stable, p_ready=0 throughout hold.
REQ-032 ACC_W=9, 5 terms of 64 (last) -> SAT_EN: acc_data=255, acc_ovf=1; no SAT_EN: acc_data=-192, acc_ovf=1.
REQ-033 Back-to-back: result 10 held, acc_ready=1 with new term -8 accepted -> result retires, next vector starts at -8, cnt=1, acc_ovf=0.
REQ-034 rst asserted after 2 of 3 terms -> outputs return to reset values, subsequent vector 1,1(last) yields 2, cnt=2.
REQ-035 300 terms of 1, last on 300th, ACC_W=12 -> acc_data=300, acc_cnt=255.

Source files
------------

// File: rtl/mult_accum.sv
// Signed dot-product accumulator behind a Booth multiplier stage: sums 8-bit product terms into an ACC_W result.
// Optional MULT_ACCUM_SAT_EN clamps the sum on overflow; without it the sum wraps modulo 2^ACC_W.
module mult_accum #(
    parameter int ACC_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             p_valid,
    input  logic [7:0]       p_data,
    input  logic             p_last,
    output logic             p_ready,
    output logic             acc_valid,
    input  logic             acc_ready,
    output logic [ACC_W-1:0] acc_data,
    output logic [7:0]       acc_cnt,
    output logic             acc_ovf
);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t           r_state;
    logic [ACC_W-1:0] r_sum;
    logic [7:0]       r_cnt;
    logic             r_ovf;

    logic             w_accept;
    logic             w_fresh;
    logic [ACC_W-1:0] w_base;
    logic [7:0]       w_base_cnt;
    logic             w_base_ovf;
    logic [ACC_W:0]   w_ext;
    logic             w_ovf;
    logic [ACC_W-1:0] w_sum_nxt;
    logic [7:0]       w_cnt_nxt;

    assign p_ready  = (r_state != HOLD) || acc_ready;
    assign w_accept = p_valid && p_ready;
    // Any term accepted outside ACCUM opens a new vector from zero, including the back-to-back HOLD case.
    assign w_fresh  = (r_state != ACCUM);

    always_comb begin
        w_base     = w_fresh ? '0 : r_sum;
        w_base_cnt = w_fresh ? 8'd0 : r_cnt;
        w_base_ovf = w_fresh ? 1'b0 : r_ovf;
        w_ext      = {w_base[ACC_W-1], w_base} + {{(ACC_W-7){p_data[7]}}, p_data};
        w_ovf      = w_ext[ACC_W] ^ w_ext[ACC_W-1];
        w_cnt_nxt  = (w_base_cnt == 8'd255) ? 8'd255 : w_base_cnt + 8'd1;
`ifdef MULT_ACCUM_SAT_EN
        // The extra top bit carries the true sign, which picks the clamp rail.
        if (!w_ovf)
            w_sum_nxt = w_ext[ACC_W-1:0];
        else if (w_ext[ACC_W])
            w_sum_nxt = {1'b1, {(ACC_W-1){1'b0}}};
        else
            w_sum_nxt = {1'b0, {(ACC_W-1){1'b1}}};
`else
        w_sum_nxt = w_ext[ACC_W-1:0];
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_sum   <= '0;
            r_cnt   <= 8'd0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_sum   <= w_sum_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ovf   <= w_base_ovf | w_ovf;
            r_state <= p_last ? HOLD : ACCUM;
        end else if (r_state == HOLD && acc_ready) begin
            r_state <= IDLE;
        end
    end

    assign acc_valid = (r_state == HOLD);
    assign acc_data  = r_sum;
    assign acc_cnt   = r_cnt;
    assign acc_ovf   = r_ovf;

endmodule

// File: tb/tb_mult_accum.sv
// Directed bench for mult_accum: a default-width instance and an ACC_W=9 instance share one stimulus stream.
// Expected sums for the 9-bit overflow case follow MULT_ACCUM_SAT_EN.
module tb_mult_accum;

    logic       clk;
    logic       rst;
    logic       p_valid;
    logic [7:0] p_data;
    logic       p_last;
    logic       acc_ready;

    logic        p_ready,   p_ready9;
    logic        acc_valid, acc_valid9;
    logic [11:0] acc_data;
    logic [8:0]  acc_data9;
    logic [7:0]  acc_cnt,   acc_cnt9;
    logic        acc_ovf,   acc_ovf9;

    int n_err = 0;
    int n_chk = 0;

    mult_accum #(.ACC_W(12)) u_dut (
        .clk(clk), .rst(rst), .p_valid(p_valid), .p_data(p_data), .p_last(p_last),
        .p_ready(p_ready), .acc_valid(acc_valid), .acc_ready(acc_ready),
        .acc_data(acc_data), .acc_cnt(acc_cnt), .acc_ovf(acc_ovf)
    );

    mult_accum #(.ACC_W(9)) u_dut9 (
        .clk(clk), .rst(rst), .p_valid(p_valid), .p_data(p_data), .p_last(p_last),
        .p_ready(p_ready9), .acc_valid(acc_valid9), .acc_ready(acc_ready),
        .acc_data(acc_data9), .acc_cnt(acc_cnt9), .acc_ovf(acc_ovf9)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        p_valid = 1'b1;
        p_data  = d;
        p_last  = l;
        @(posedge clk); #1;
        p_valid = 1'b0;
        p_last  = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic signed [31:0] d,
                           input logic [7:0] c, input logic o);
        chk({tag, "_valid"}, {31'd0, acc_valid}, {31'd0, v});
        chk({tag, "_data"},  $signed(acc_data), d);
        chk({tag, "_cnt"},   {24'd0, acc_cnt}, {24'd0, c});
        chk({tag, "_ovf"},   {31'd0, acc_ovf}, {31'd0, o});
    endtask

    initial begin
        // reset with a term offered: nothing may be accepted
        rst = 1'b1; p_valid = 1'b1; p_data = 8'd5; p_last = 1'b1; acc_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; p_valid = 1'b0; p_last = 1'b0;
        @(negedge clk);
        chk_out("reset", 1'b0, 0, 8'd0, 1'b0);
        chk("reset_data9", $signed(acc_data9), 0);
        chk("reset_pready", {31'd0, p_ready}, 1);

        // 3, -5, 7(last) -> 5
        @(posedge clk); #1;
        acc_ready = 1'b1;
        send(8'd3, 1'b0);
        send(8'hFB, 1'b0);
        send(8'd7, 1'b1);
        @(negedge clk);
        chk_out("basic", 1'b1, 5, 8'd3, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("basic_retire", {31'd0, acc_valid}, 0);

        // single term -56 held for 4 cycles while a stray term is offered
        @(posedge clk); #1;
        acc_ready = 1'b0;
        send(8'hC8, 1'b1);
        p_valid = 1'b1; p_data = 8'd9; p_last = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_out("hold", 1'b1, -56, 8'd1, 1'b0);
            chk("hold_pready", {31'd0, p_ready}, 0);
            @(posedge clk); #1;
        end
        p_valid = 1'b0; p_last = 1'b0; acc_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("hold_retire", {31'd0, acc_valid}, 0);

        // five terms of 64: overflows the 9-bit instance only
        @(posedge clk); #1;
        acc_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(8'd64, 1'b0);
        send(8'd64, 1'b1);
        @(negedge clk);
        chk_out("ovf12", 1'b1, 320, 8'd5, 1'b0);
`ifdef MULT_ACCUM_SAT_EN
        chk("ovf9_data", $signed(acc_data9), 255);
`else
        chk("ovf9_data", $signed(acc_data9), -192);
`endif
        chk("ovf9_flag", {31'd0, acc_ovf9}, 1);
        chk("ovf9_cnt", {24'd0, acc_cnt9}, 5);

        // back-to-back from an overflowed result: new vector starts clean
        acc_ready = 1'b1;
        send(8'hF8, 1'b0);
        @(negedge clk);
        chk_out("b2b_ovfclr", 1'b0, -8, 8'd1, 1'b0);
        chk("b2b_ovfclr9", {31'd0, acc_ovf9}, 0);
        chk("b2b_data9", $signed(acc_data9), -8);

        // result 10 held, then retired by a new term -8 in the same cycle
        acc_ready = 1'b0;
        send(8'd18, 1'b1);
        @(negedge clk);
        chk_out("b2b_hold", 1'b1, 10, 8'd2, 1'b0);
        @(posedge clk); #1;
        acc_ready = 1'b1;
        send(8'hF8, 1'b0);
        @(negedge clk);
        chk_out("b2b_new", 1'b0, -8, 8'd1, 1'b0);
        send(8'd2, 1'b1);
        @(negedge clk);
        chk_out("b2b_next", 1'b1, -6, 8'd2, 1'b0);
        @(posedge clk); #1;

        // reset mid-vector discards the partial sum
        send(8'd1, 1'b0);
        send(8'd1, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_out("midrst", 1'b0, 0, 8'd0, 1'b0);
        @(posedge clk); #1;
        send(8'd1, 1'b0);
        send(8'd1, 1'b1);
        @(negedge clk);
        chk_out("postrst", 1'b1, 2, 8'd2, 1'b0);
        @(posedge clk); #1;

        // 300 unit terms: count saturates, sum does not
        for (int i = 0; i < 300; i++) send(8'd1, (i == 299));
        @(negedge clk);
        chk_out("cntsat", 1'b1, 300, 8'd255, 1'b0);
        chk("cntsat9", {24'd0, acc_cnt9}, 255);
        @(posedge clk); #1;
        @(negedge clk);
        chk("final_idle", {31'd0, acc_valid}, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
